// File: rtl/hazard_pkg.sv
// Shared encodings and limits for the hazard scoreboard: forwarding-select codes,
// the multi-cycle occupancy bound and the width of the in-flight counter.
package hazard_pkg;

    localparam int MC_CNT_W     = 4;
    localparam int MC_MAX_LIMIT = 15;

    typedef enum logic [1:0] {
        FWD_RF       = 2'b00,
        FWD_EXE_ALU  = 2'b01,
        FWD_MEM_ALU  = 2'b10,
        FWD_MEM_LOAD = 2'b11
    } fwd_sel_e;

    // EXE is the youngest producer, so it shadows a MEM match on the same register.
    function automatic fwd_sel_e fwd_pick(input logic exe_hit, input logic mem_hit,
                                          input logic mem_is_load);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (exe_hit) begin
            sel = FWD_EXE_ALU;
        end else if (mem_hit) begin
            sel = mem_is_load ? FWD_MEM_LOAD : FWD_MEM_ALU;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_sb_bank.sv
// Pending-write bits for multi-cycle destinations plus the in-flight op counter.
// Register 0 never holds a pending bit; a same-cycle set and clear of one bit leaves it set.
module hazard_sb_bank
    import hazard_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        set_en_i,
    input  logic [$clog2(NREG)-1:0]     set_idx_i,
    input  logic                        clr_en_i,
    input  logic [$clog2(NREG)-1:0]     clr_idx_i,
    output logic [NREG-1:0]             pending_o,
    output logic [MC_CNT_W-1:0]         outstanding_o
);

    localparam int RAW = $clog2(NREG);

    logic [NREG-1:1]     pend_q;
    logic [MC_CNT_W-1:0] cnt_q;
    logic [MC_CNT_W-1:0] cnt_d;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_pend
            always_ff @(posedge clk) begin
                if (!rst) begin
                    pend_q[gi] <= 1'b0;
                end else if (set_en_i && (set_idx_i == RAW'(gi))) begin
                    pend_q[gi] <= 1'b1;
                end else if (clr_en_i && (clr_idx_i == RAW'(gi))) begin
                    pend_q[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // A writeback with nothing in flight must not wrap the counter.
    always_comb begin
        cnt_d = cnt_q;
        if (set_en_i && !(clr_en_i && (cnt_q != '0))) begin
            cnt_d = cnt_q + MC_CNT_W'(1);
        end else if (!set_en_i && clr_en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - MC_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pending_o     = {pend_q, 1'b0};
    assign outstanding_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: forwarding selects, load-use / scoreboard / structural stalls,
// branch flush. Optional perf counters (stall_cnt, flush_cnt) under HAZARD_PERF_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int MC_MAX = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(NREG)-1:0]     rs1_ID,
    input  logic [$clog2(NREG)-1:0]     rs2_ID,
    input  logic [$clog2(NREG)-1:0]     rd_ID,
    input  logic                        rs1use_ID,
    input  logic                        rs2use_ID,
    input  logic                        branch_taken_ID,
    input  logic                        mc_issue_ID,
    input  logic [$clog2(NREG)-1:0]     rd_EXE,
    input  logic [$clog2(NREG)-1:0]     rd_MEM,
    input  logic                        RegWrite_EXE,
    input  logic                        DatatoReg_EXE,
    input  logic                        RegWrite_MEM,
    input  logic                        DatatoReg_MEM,
    input  logic                        mem_w_EXE,
    input  logic [$clog2(NREG)-1:0]     rs2_EXE,
    input  logic                        mc_wb_valid,
    input  logic [$clog2(NREG)-1:0]     mc_wb_rd,
    output logic                        pc_en_IF,
    output logic                        reg_FD_stall,
    output logic                        reg_FD_flush,
    output logic                        reg_DE_flush,
    output logic [1:0]                  fwd_sel_A,
    output logic [1:0]                  fwd_sel_B,
    output logic                        fwd_ls,
    output logic [NREG-1:0]             mc_pending,
    output logic [3:0]                  mc_outstanding
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                 stall_cnt,
    output logic [31:0]                 flush_cnt
`endif
);

    localparam logic [MC_CNT_W-1:0] MC_MAX_C = MC_CNT_W'(MC_MAX);

    logic                rs1_act;
    logic                rs2_act;
    logic                load_use;
    logic                sb_hazard;
    logic                struct_hazard;
    logic                stall;
    logic                issue_ok;
    logic [NREG-1:0]     pend;
    logic [MC_CNT_W-1:0] outst;

    assign rs1_act = rs1use_ID && (rs1_ID != '0);
    assign rs2_act = rs2use_ID && (rs2_ID != '0);

    assign fwd_sel_A = fwd_pick(rs1_act && RegWrite_EXE && (rd_EXE == rs1_ID),
                                rs1_act && RegWrite_MEM && (rd_MEM == rs1_ID),
                                DatatoReg_MEM);
    assign fwd_sel_B = fwd_pick(rs2_act && RegWrite_EXE && (rd_EXE == rs2_ID),
                                rs2_act && RegWrite_MEM && (rd_MEM == rs2_ID),
                                DatatoReg_MEM);

    // Load data arriving in MEM feeds a store's data operand sitting in EXE.
    assign fwd_ls = mem_w_EXE && RegWrite_MEM && DatatoReg_MEM
                 && (rd_MEM == rs2_EXE) && (rs2_EXE != '0);

    assign load_use = RegWrite_EXE && DatatoReg_EXE
                   && ((rs1_act && (rs1_ID == rd_EXE)) || (rs2_act && (rs2_ID == rd_EXE)));

    // No bypass from a same-cycle writeback; the regfile write-then-read covers the next cycle.
    assign sb_hazard = (rs1_act && pend[rs1_ID])
                    || (rs2_act && pend[rs2_ID])
                    || (mc_issue_ID && pend[rd_ID]);

    assign struct_hazard = mc_issue_ID && (outst == MC_MAX_C) && !mc_wb_valid;

    assign stall    = load_use || sb_hazard || struct_hazard;
    assign issue_ok = mc_issue_ID && !stall;

    always_comb begin
        pc_en_IF     = 1'b1;
        reg_FD_stall = 1'b0;
        reg_FD_flush = 1'b0;
        reg_DE_flush = 1'b0;
        if (stall) begin
            pc_en_IF     = 1'b0;
            reg_FD_stall = 1'b1;
            reg_DE_flush = 1'b1;
        end else if (branch_taken_ID) begin
            reg_FD_flush = 1'b1;
        end
    end

    hazard_sb_bank #(
        .NREG (NREG)
    ) u_sb_bank (
        .clk           (clk),
        .rst           (rst),
        .set_en_i      (issue_ok),
        .set_idx_i     (rd_ID),
        .clr_en_i      (mc_wb_valid),
        .clr_idx_i     (mc_wb_rd),
        .pending_o     (pend),
        .outstanding_o (outst)
    );

    assign mc_pending     = pend;
    assign mc_outstanding = outst;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (reg_FD_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized + directed bench for hazard_scoreboard: a driver pushes expected outputs
// from a reference model into a queue, a negedge monitor pops and compares.
module tb_hazard_scoreboard;

    localparam int NREG   = 32;
    localparam int MC_MAX = 2;
    localparam int RAW    = $clog2(NREG);

    logic           clk;
    logic           rst;
    logic [RAW-1:0] rs1_ID, rs2_ID, rd_ID, rd_EXE, rd_MEM, rs2_EXE, mc_wb_rd;
    logic           rs1use_ID, rs2use_ID, branch_taken_ID, mc_issue_ID;
    logic           RegWrite_EXE, DatatoReg_EXE, RegWrite_MEM, DatatoReg_MEM, mem_w_EXE;
    logic           mc_wb_valid;
    logic           pc_en_IF, reg_FD_stall, reg_FD_flush, reg_DE_flush, fwd_ls;
    logic [1:0]     fwd_sel_A, fwd_sel_B;
    logic [NREG-1:0] mc_pending;
    logic [3:0]     mc_outstanding;
`ifdef HAZARD_PERF_EN
    logic [31:0]    stall_cnt, flush_cnt;
`endif

    hazard_scoreboard #(.NREG(NREG), .MC_MAX(MC_MAX)) dut (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
        .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
        .branch_taken_ID(branch_taken_ID), .mc_issue_ID(mc_issue_ID),
        .rd_EXE(rd_EXE), .rd_MEM(rd_MEM),
        .RegWrite_EXE(RegWrite_EXE), .DatatoReg_EXE(DatatoReg_EXE),
        .RegWrite_MEM(RegWrite_MEM), .DatatoReg_MEM(DatatoReg_MEM),
        .mem_w_EXE(mem_w_EXE), .rs2_EXE(rs2_EXE),
        .mc_wb_valid(mc_wb_valid), .mc_wb_rd(mc_wb_rd),
        .pc_en_IF(pc_en_IF), .reg_FD_stall(reg_FD_stall),
        .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
        .fwd_sel_A(fwd_sel_A), .fwd_sel_B(fwd_sel_B), .fwd_ls(fwd_ls),
        .mc_pending(mc_pending), .mc_outstanding(mc_outstanding)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic            pc_en, fd_stall, fd_flush, de_flush, fls;
        logic [1:0]      fa, fb;
        logic [NREG-1:0] pend;
        logic [3:0]      cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   txn      = 0;

    // Reference state: which registers await a multi-cycle result, and how many ops are in flight.
    bit   m_pend[NREG];
    int   m_cnt = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [RAW-1:0] r, input logic used);
        if (!used || r == 0) return 2'b00;
        if (RegWrite_EXE && rd_EXE == r) return 2'b01;
        if (RegWrite_MEM && rd_MEM == r) return DatatoReg_MEM ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    // Compute expected outputs for the current inputs, queue them, then advance the model.
    task automatic step();
        exp_t e;
        logic [RAW-1:0] srcs[2];
        logic           used[2];
        bit lu, sb, st, stall;
        srcs[0] = rs1_ID; used[0] = rs1use_ID;
        srcs[1] = rs2_ID; used[1] = rs2use_ID;
        lu = 0; sb = 0;
        for (int s = 0; s < 2; s++) begin
            if (used[s] && srcs[s] != 0) begin
                if (RegWrite_EXE && DatatoReg_EXE && srcs[s] == rd_EXE) lu = 1;
                if (m_pend[srcs[s]]) sb = 1;
            end
        end
        if (mc_issue_ID && m_pend[rd_ID]) sb = 1;
        st    = mc_issue_ID && (m_cnt == MC_MAX) && !mc_wb_valid;
        stall = lu || sb || st;
        e.pc_en    = !stall;
        e.fd_stall = stall;
        e.de_flush = stall;
        e.fd_flush = !stall && branch_taken_ID;
        e.fa       = ref_fwd(rs1_ID, rs1use_ID);
        e.fb       = ref_fwd(rs2_ID, rs2use_ID);
        e.fls      = mem_w_EXE && RegWrite_MEM && DatatoReg_MEM && rd_MEM == rs2_EXE && rs2_EXE != 0;
        e.cnt      = 4'(m_cnt);
        for (int r = 0; r < NREG; r++) e.pend[r] = m_pend[r];
        exp_q.push_back(e);
        if (!rst) begin
            for (int r = 0; r < NREG; r++) m_pend[r] = 0;
            m_cnt = 0;
        end else begin
            if (mc_wb_valid) begin
                m_pend[mc_wb_rd] = 0;
                if (m_cnt > 0) m_cnt = m_cnt - 1;
            end
            if (mc_issue_ID && !stall) begin
                if (rd_ID != 0) m_pend[rd_ID] = 1;
                m_cnt = m_cnt + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                cmp("pc_en_IF",       32'(pc_en_IF),       32'(e.pc_en));
                cmp("reg_FD_stall",   32'(reg_FD_stall),   32'(e.fd_stall));
                cmp("reg_FD_flush",   32'(reg_FD_flush),   32'(e.fd_flush));
                cmp("reg_DE_flush",   32'(reg_DE_flush),   32'(e.de_flush));
                cmp("fwd_sel_A",      32'(fwd_sel_A),      32'(e.fa));
                cmp("fwd_sel_B",      32'(fwd_sel_B),      32'(e.fb));
                cmp("fwd_ls",         32'(fwd_ls),         32'(e.fls));
                cmp("mc_pending",     mc_pending,          e.pend);
                cmp("mc_outstanding", 32'(mc_outstanding), 32'(e.cnt));
                $display("txn %0d: pc_en=%0b stall=%0b flush=%0b fA=%0d fB=%0d ls=%0b pend=%08h cnt=%0d",
                         txn, pc_en_IF, reg_FD_stall, reg_FD_flush, fwd_sel_A, fwd_sel_B,
                         fwd_ls, mc_pending, mc_outstanding);
            end
        end
    end

    task automatic idle();
        rst = 1; rs1_ID = 0; rs2_ID = 0; rd_ID = 0; rs1use_ID = 0; rs2use_ID = 0;
        branch_taken_ID = 0; mc_issue_ID = 0; rd_EXE = 0; rd_MEM = 0; rs2_EXE = 0;
        RegWrite_EXE = 0; DatatoReg_EXE = 0; RegWrite_MEM = 0; DatatoReg_MEM = 0;
        mem_w_EXE = 0; mc_wb_valid = 0; mc_wb_rd = 0;
    endtask

    task automatic issue(input int r);
        idle(); mc_issue_ID = 1; rd_ID = RAW'(r); step();
    endtask

    task automatic wb(input int r);
        idle(); mc_wb_valid = 1; mc_wb_rd = RAW'(r); step();
    endtask

    initial begin
        idle();
        rst = 0;
        for (int r = 0; r < NREG; r++) m_pend[r] = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state with idle inputs
        idle(); #1;
        cmp("rst_pc_en", 32'(pc_en_IF), 1);
        cmp("rst_flush", 32'({reg_FD_stall, reg_FD_flush, reg_DE_flush, fwd_ls}), 0);
        cmp("rst_fwd",   32'({fwd_sel_A, fwd_sel_B}), 0);
        step();

        // ALU result in EXE forwarded; x0 never forwarded
        idle(); rd_EXE = 5; RegWrite_EXE = 1; rs1_ID = 5; rs1use_ID = 1; #1;
        cmp("exe_fwd_A", 32'(fwd_sel_A), 1);
        cmp("exe_fwd_nostall", 32'(pc_en_IF), 1);
        step();
        idle(); rd_EXE = 0; RegWrite_EXE = 1; rs1_ID = 0; rs1use_ID = 1; #1;
        cmp("x0_fwd_A", 32'(fwd_sel_A), 0);
        step();

        // Load-use: one bubble, then load data forwarded from MEM
        idle(); rd_EXE = 7; RegWrite_EXE = 1; DatatoReg_EXE = 1; rs2_ID = 7; rs2use_ID = 1; #1;
        cmp("lu_pc_en", 32'(pc_en_IF), 0);
        cmp("lu_de_flush", 32'(reg_DE_flush), 1);
        step();
        idle(); rd_MEM = 7; RegWrite_MEM = 1; DatatoReg_MEM = 1; rs2_ID = 7; rs2use_ID = 1; #1;
        cmp("lu_fwd_B", 32'(fwd_sel_B), 3);
        cmp("lu_release", 32'(pc_en_IF), 1);
        step();

        // Divide to x9: consumer held until writeback, released one cycle later
        issue(9);
        idle(); rs1_ID = 9; rs1use_ID = 1; #1;
        cmp("div_pending9", 32'(mc_pending[9]), 1);
        cmp("div_stall", 32'(pc_en_IF), 0);
        step(); step();
        mc_wb_valid = 1; mc_wb_rd = 9; #1;
        cmp("div_wb_still_stall", 32'(pc_en_IF), 0);
        step();
        mc_wb_valid = 0; #1;
        cmp("div_released", 32'(pc_en_IF), 1);
        cmp("div_cnt0", 32'(mc_outstanding), 0);
        step();

        // Structural limit, then issue accepted alongside a writeback
        issue(10); issue(11);
        idle(); mc_issue_ID = 1; rd_ID = 12; #1;
        cmp("struct_cnt", 32'(mc_outstanding), 2);
        cmp("struct_stall", 32'(pc_en_IF), 0);
        step();
        mc_wb_valid = 1; mc_wb_rd = 10; #1;
        cmp("struct_wb_accept", 32'(pc_en_IF), 1);
        step();
        idle(); #1;
        cmp("struct_cnt_held", 32'(mc_outstanding), 2);
        cmp("struct_pend12", 32'(mc_pending[12]), 1);
        step();

        // Stall beats branch; branch alone flushes
        idle(); rd_EXE = 3; RegWrite_EXE = 1; DatatoReg_EXE = 1; rs1_ID = 3; rs1use_ID = 1;
        branch_taken_ID = 1; #1;
        cmp("br_stall_noflush", 32'(reg_FD_flush), 0);
        step();
        idle(); branch_taken_ID = 1; #1;
        cmp("br_flush", 32'(reg_FD_flush), 1);
        step();

        // Reset mid-operation with x3, x4 pending
        wb(11); wb(12); issue(3); issue(4);
        idle(); rst = 0; rs1_ID = 3; rs1use_ID = 1; step();
        idle(); rs1_ID = 3; rs1use_ID = 1; #1;
        cmp("rst_mid_pend", mc_pending, 0);
        cmp("rst_mid_cnt", 32'(mc_outstanding), 0);
        cmp("rst_mid_nostall", 32'(pc_en_IF), 1);
        step();

        // Randomized traffic on a narrow register window to provoke collisions
        for (int i = 0; i < 1500; i++) begin
            rst             = ($urandom_range(0, 59) != 0);
            rs1_ID          = RAW'($urandom_range(0, 7));
            rs2_ID          = RAW'($urandom_range(0, 7));
            rd_ID           = RAW'($urandom_range(0, 7));
            rd_EXE          = RAW'($urandom_range(0, 7));
            rd_MEM          = RAW'($urandom_range(0, 7));
            rs2_EXE         = RAW'($urandom_range(0, 7));
            mc_wb_rd        = RAW'($urandom_range(0, 7));
            rs1use_ID       = 1'($urandom_range(0, 1));
            rs2use_ID       = 1'($urandom_range(0, 1));
            branch_taken_ID = ($urandom_range(0, 3) == 0);
            mc_issue_ID     = ($urandom_range(0, 2) == 0);
            RegWrite_EXE    = 1'($urandom_range(0, 1));
            DatatoReg_EXE   = ($urandom_range(0, 3) == 0);
            RegWrite_MEM    = 1'($urandom_range(0, 1));
            DatatoReg_MEM   = 1'($urandom_range(0, 1));
            mem_w_EXE       = 1'($urandom_range(0, 1));
            mc_wb_valid     = ($urandom_range(0, 2) == 0);
            step();
        end

        idle();
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        cmp("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, architectural register count (power of 2, >=2); RAW=log2(NREG).
REQ-002 SHALL have parameter MC_MAX, default 2, max outstanding multi-cycle (mul/div) ops, 1..15.
REQ-003 SHALL use one clock; reset is synchronous and active-low; ports are named clk and rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-low reset.
REQ-006 rs1_ID, rs2_ID, rd_ID  in  RAW each  ID-stage source/destination indices.
REQ-007 rs1use_ID, rs2use_ID  in  1 each  source actually read by ID instruction.
REQ-008 branch_taken_ID  in  1  ID resolved a taken branch/jump.
REQ-009 mc_issue_ID  in  1  ID instruction is a multi-cycle op writing rd_ID.
REQ-010 rd_EXE, rd_MEM  in  RAW each; RegWrite_EXE, DatatoReg_EXE, RegWrite_MEM, DatatoReg_MEM, mem_w_EXE  in  1 each; rs2_EXE  in  RAW.
REQ-011 mc_wb_valid  in  1; mc_wb_rd  in  RAW  multi-cycle unit writeback.
REQ-012 pc_en_IF, reg_FD_stall, reg_FD_flush, reg_DE_flush  out  1 each  pipeline control.
REQ-013 fwd_sel_A, fwd_sel_B  out  2 each  (00 regfile, 01 EXE ALU, 10 MEM ALU, 11 MEM load); fwd_ls  out  1.
REQ-014 mc_pending  out  NREG  scoreboard bits; mc_outstanding  out  4  in-flight count.

Function
REQ-015 fwd_sel_A/B SHALL be combinational: source nonzero and used; EXE match with RegWrite_EXE -> 01, else MEM match with RegWrite_MEM -> 11 if DatatoReg_MEM else 10, else 00.
REQ-016 fwd_ls SHALL be 1 iff mem_w_EXE & RegWrite_MEM & DatatoReg_MEM & rd_MEM==rs2_EXE & rs2_EXE!=0.
REQ-017 load-use SHALL assert when a used nonzero source equals rd_EXE with RegWrite_EXE & DatatoReg_EXE.
REQ-018 sb_hazard SHALL assert when a used nonzero source, or rd_ID when mc_issue_ID, has its mc_pending bit set (RAW/WAW).
REQ-019 struct_hazard SHALL assert when mc_issue_ID and mc_outstanding==MC_MAX and not mc_wb_valid.
REQ-020 stall = load-use | sb_hazard | struct_hazard; stall SHALL drive pc_en_IF=0, reg_FD_stall=1, reg_DE_flush=1, reg_FD_flush=0.
REQ-021 without stall, branch_taken_ID SHALL give reg_FD_flush=1, pc_en_IF=1; stall has priority over branch.
REQ-022 issue accepted = mc_issue_ID & ~stall; SHALL set mc_pending[rd_ID] next cycle unless rd_ID==0, and increment mc_outstanding.
REQ-023 mc_wb_valid SHALL clear mc_pending[mc_wb_rd] and decrement mc_outstanding next cycle.
REQ-024 accepted issue and writeback same cycle: count unchanged; same rd -> bit ends set (issue wins).
REQ-025 mc_pending[0] SHALL read 0 always; writeback with count 0 SHALL not underflow (count held).
REQ-026 scoreboard SHALL not bypass same-cycle writeback: pending source stalls one extra cycle (regfile write-then-read covers it).

Reset
REQ-027 rst low at posedge SHALL clear mc_pending, mc_outstanding and perf counters, including mid-operation; combinational outputs follow cleared state.
REQ-028 after reset with idle inputs: pc_en_IF=1, all stall/flush=0, fwd_sel=00, fwd_ls=0.

Configuration
REQ-029 macro HAZARD_PERF_EN defined SHALL add outputs stall_cnt, flush_cnt (32-bit, saturating at all-ones) counting stall cycles and reg_FD_flush cycles.
REQ-030 HAZARD_PERF_EN undefined SHALL omit those ports and registers; other behaviour identical.

Structure
REQ-031 fwd_sel encodings, MC_MAX bound and counter width SHALL live in package hazard_pkg.
REQ-032 pending bits and outstanding counter SHALL be sub-module hazard_sb_bank (set/clear/count); detection logic stays at top.

Verification
REQ-033 EXE add x5, ID uses rs1=x5 -> fwd_sel_A=01, no stall; same with x0 -> 00.
REQ-034 EXE load x7, ID rs2=x7 used -> one cycle pc_en_IF=0, reg_DE_flush=1, then fwd_sel_B=11.
REQ-035 issue div to x9, next ID reads x9 -> stall until mc_wb_valid rd=9, released one cycle later.
REQ-036 MC_MAX=2, two accepted issues, third issue -> struct stall; simultaneous writeback -> third accepted, count stays 2.
REQ-037 stall and branch_taken_ID together -> reg_FD_flush=0; branch alone -> reg_FD_flush=1.
REQ-038 rst low with x3,x4 pending, count 2 -> next cycle mc_pending=0, count=0, no stall.
